host_write_decoder: RTL

- Consumes host bus strobes after they have passed the 2-stage synchronizer into the `clk` domain.
- Detects completed host writes and decodes OPL2 port semantics: A0=0 selects the register address, A0=1 writes register data.
- Queues {address, data} pairs in a small FIFO.
- Presents them to the register-file write port through a valid/ready handshake.

---
 rtl/host_write_decoder_pkg.sv | 16 +
 rtl/host_write_decoder_sync_fifo.sv | 50 +++++
 rtl/host_write_decoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/host_write_decoder_pkg.sv
// Shared types and constants for the host write path into the register file.
package host_if_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_write_t;

  // A0 selects which host port a write targets
  localparam logic PORT_ADDR = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/host_write_decoder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full queue still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/host_write_decoder.sv
// Decodes synchronized host strobes into OPL2 address/data writes and queues
// {address, data} pairs for the register file.
module host_write_decoder
  import host_if_pkg::*;
#(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n_sync,
  input  logic                  wr_n_sync,
  input  logic                  a0_sync,
  input  logic [DATA_WIDTH-1:0] din_sync,
  input  logic                  overflow_clr,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic                  wr_n_q, wr_n_qq, cs_n_q, cs_n_qq, a0_q, a0_h;
  logic [DATA_WIDTH-1:0] din_q, din_h;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  hi_seen, armed;
  logic                  wr_evt, push, drop, full, empty;
  entry_t                push_e, head_e;

  // armed only once a high strobe was sampled before the current low phase,
  // so a strobe already low across reset is ignored until it cycles again
  assign wr_evt = armed && wr_n_q && !wr_n_qq && !cs_n_qq;
  assign push   = wr_evt && (a0_h == PORT_DATA);
  assign drop   = push && full && !wr_ready;
  assign push_e = '{addr: addr_q, data: din_h};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_n_q  <= 1'b1;
      wr_n_qq <= 1'b1;
      cs_n_q  <= 1'b1;
      cs_n_qq <= 1'b1;
      a0_q    <= 1'b0;
      din_q   <= '0;
      a0_h    <= 1'b0;
      din_h   <= '0;
      addr_q  <= '0;
      hi_seen <= 1'b0;
      armed   <= 1'b0;
    end else begin
      wr_n_q  <= wr_n_sync;
      wr_n_qq <= wr_n_q;
      cs_n_q  <= cs_n_sync;
      cs_n_qq <= cs_n_q;
      a0_q    <= a0_sync;
      din_q   <= din_sync;
      hi_seen <= hi_seen | wr_n_sync;
      armed   <= hi_seen;
      if (!cs_n_q && !wr_n_q) begin
        a0_h  <= a0_q;
        din_h <= din_q;
      end
      if (wr_evt && (a0_h == PORT_ADDR)) addr_q <= din_h[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_e),
    .pop   (wr_ready),
    .rdata (head_e),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign wr_valid = !empty;
  assign wr_addr  = head_e.addr;
  assign wr_data  = head_e.data;

endmodule
